// File: rtl/wave_measure.sv
// wave_measure: windowed waveform measurement over 2^LOG2_WIN strobed samples.
// Reports mean (dc_offset), peak-to-peak (vpp), crest ratio floor(4*vpp^2/var)
// saturated at 255, and a square/sine/triangle class. Also streams a
// DC-removed signed copy of the input.
//   clk, rst          : clock, synchronous active-high reset
//   sample_valid/data : strobe-qualified unsigned ADC sample
//   ac_valid/ac_data  : sample_data - dc_offset, one cycle later
//   dc_offset, vpp    : mean and max-min of the last completed window
//   ratio, wave_type  : crest ratio and class (00 none, 01 sq, 10 sine, 11 tri)
//   result_valid      : one-cycle pulse when the result outputs update
module wave_measure #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOG2_WIN = 10,
  parameter int unsigned SQ_MAX   = 24,
  parameter int unsigned TRI_MIN  = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_data,
  output logic                   ac_valid,
  output logic signed [DATA_W:0] ac_data,
  output logic [DATA_W-1:0]      dc_offset,
  output logic [DATA_W-1:0]      vpp,
  output logic [7:0]             ratio,
  output logic [1:0]             wave_type,
  output logic                   result_valid
);

  localparam int unsigned SX_W   = DATA_W + LOG2_WIN;
  localparam int unsigned SQ_W   = 2 * DATA_W;
  localparam int unsigned SX2_W  = 2 * DATA_W + LOG2_WIN;
  localparam int unsigned PROD_W = 2 * DATA_W + 2 * LOG2_WIN;
  localparam int unsigned VAR_W  = 2 * DATA_W;
  localparam int unsigned NUM_W  = 2 * DATA_W + 2;
  localparam int unsigned DVS_W  = 2 * DATA_W + 7;
  localparam int unsigned SAT_W  = 2 * DATA_W + 8;
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {ST_ACC, ST_VAR, ST_SAT, ST_DIV, ST_OUT} state_t;

  // Accumulators and window-end snapshots
  logic [LOG2_WIN-1:0] cnt_q;
  logic [SX_W-1:0]     sx_q, snap_sx_q, sx_nxt_c;
  logic [SX2_W-1:0]    sx2_q, snap_sx2_q, sx2_nxt_c;
  logic [DATA_W-1:0]   mx_q, mn_q, snap_mx_q, snap_mn_q, mx_nxt_c, mn_nxt_c;
  logic                win_end_c;

  // Result pipeline
  state_t              state_q, state_d;
  logic [2:0]          div_cnt_q;
  logic                load_c;
  logic [VAR_W-1:0]    var_q, var_c;
  logic [DATA_W-1:0]   mean_q, pp_q;
  logic [NUM_W-1:0]    rem_q, num_c;
  logic [DVS_W-1:0]    dvs_q;
  logic [6:0]          quo_q;
  logic                zero_q, sat_q, div_bit_c;
  logic [7:0]          quo_c, ratio_c;
  logic [1:0]          class_c;

  // Running sums/extremes including the current sample
  always_comb begin
    sx_nxt_c  = sx_q + SX_W'(sample_data);
    sx2_nxt_c = sx2_q + SX2_W'(SQ_W'(sample_data) * SQ_W'(sample_data));
    mx_nxt_c  = (sample_data > mx_q) ? sample_data : mx_q;
    mn_nxt_c  = (sample_data < mn_q) ? sample_data : mn_q;
    win_end_c = sample_valid && (cnt_q == '1);
  end

  // Accumulate; on the closing sample snapshot and restart with no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sx_q       <= '0;
      sx2_q      <= '0;
      mx_q       <= '0;
      mn_q       <= '1;
      snap_sx_q  <= '0;
      snap_sx2_q <= '0;
      snap_mx_q  <= '0;
      snap_mn_q  <= '0;
    end else if (sample_valid) begin
      cnt_q <= cnt_q + LOG2_WIN'(1);
      if (win_end_c) begin
        snap_sx_q  <= sx_nxt_c;
        snap_sx2_q <= sx2_nxt_c;
        snap_mx_q  <= mx_nxt_c;
        snap_mn_q  <= mn_nxt_c;
        sx_q       <= '0;
        sx2_q      <= '0;
        mx_q       <= '0;
        mn_q       <= '1;
      end else begin
        sx_q  <= sx_nxt_c;
        sx2_q <= sx2_nxt_c;
        mx_q  <= mx_nxt_c;
        mn_q  <= mn_nxt_c;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // Next state; outputs load on the last divider step so they show in OUT
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      ST_ACC: if (win_end_c) state_d = ST_VAR;
      ST_VAR: state_d = ST_SAT;
      ST_SAT: state_d = ST_DIV;
      ST_DIV: begin
        if (div_cnt_q == 3'd7) begin
          state_d = ST_OUT;
          load_c  = 1'b1;
        end
      end
      ST_OUT: state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // Variance, divider step and classification
  always_comb begin
    // N*sum_x2 >= sum_x^2 always, so the difference is non-negative
    var_c = VAR_W'(((PROD_W'(snap_sx2_q) << LOG2_WIN)
                    - (PROD_W'(snap_sx_q) * PROD_W'(snap_sx_q))) >> (2 * LOG2_WIN));
    num_c     = (NUM_W'(pp_q) * NUM_W'(pp_q)) << 2;
    div_bit_c = !zero_q && !sat_q && (DVS_W'(rem_q) >= dvs_q);
    quo_c     = {quo_q, div_bit_c};
    ratio_c   = sat_q ? 8'hFF : quo_c;
    if (zero_q)                       class_c = 2'b00;
    else if (32'(ratio_c) < SQ_MAX)   class_c = 2'b01;
    else if (32'(ratio_c) >= TRI_MIN) class_c = 2'b11;
    else                              class_c = 2'b10;
  end

  // Result datapath: stats, saturation test, restoring divide MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      var_q     <= '0;
      mean_q    <= '0;
      pp_q      <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      zero_q    <= 1'b0;
      sat_q     <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_VAR: begin
          var_q  <= var_c;
          mean_q <= DATA_W'(snap_sx_q >> LOG2_WIN);
          pp_q   <= snap_mx_q - snap_mn_q;
        end
        ST_SAT: begin
          zero_q    <= (var_q == '0);
          sat_q     <= (var_q != '0) && (SAT_W'(num_c) >= (SAT_W'(var_q) << 8));
          rem_q     <= num_c;
          dvs_q     <= DVS_W'(var_q) << 7;
          quo_q     <= '0;
          div_cnt_q <= '0;
        end
        ST_DIV: begin
          if (div_bit_c) rem_q <= rem_q - NUM_W'(dvs_q);
          dvs_q     <= dvs_q >> 1;
          quo_q     <= quo_c[6:0];
          div_cnt_q <= div_cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and DC-removed stream
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_offset    <= MIDSCALE;
      vpp          <= '0;
      ratio        <= '0;
      wave_type    <= '0;
      result_valid <= 1'b0;
      ac_valid     <= 1'b0;
      ac_data      <= '0;
    end else begin
      result_valid <= load_c;
      ac_valid     <= sample_valid;
      ac_data      <= $signed({1'b0, sample_data}) - $signed({1'b0, dc_offset});
      if (load_c) begin
        dc_offset <= mean_q;
        vpp       <= pp_q;
        ratio     <= ratio_c;
        wave_type <= class_c;
      end
    end
  end

endmodule

// File: tb/tb_wave_measure.sv
// Scoreboard bench for wave_measure with a 32-sample window.
module tb_wave_measure;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned LOG2_WIN = 5;
  localparam int          WIN      = 32;
  localparam real         PI       = 3.141592653589793;

  typedef struct {
    logic [7:0] dc;
    logic [7:0] pp;
    logic [7:0] rt;
    logic [1:0] wt;
    int         cyc;
  } res_t;
  typedef int win_t[WIN];

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sample_valid;
  logic [DATA_W-1:0]      sample_data;
  logic                   ac_valid;
  logic signed [DATA_W:0] ac_data;
  logic [DATA_W-1:0]      dc_offset;
  logic [DATA_W-1:0]      vpp;
  logic [7:0]             ratio;
  logic [1:0]             wave_type;
  logic                   result_valid;

  wave_measure #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN), .SQ_MAX(24), .TRI_MIN(40)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .ac_valid(ac_valid), .ac_data(ac_data), .dc_offset(dc_offset), .vpp(vpp),
    .ratio(ratio), .wave_type(wave_type), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  res_t                   exp_q[$];
  res_t                   got_q[$];
  logic signed [DATA_W:0] ac_exp_q[$];
  logic signed [DATA_W:0] ac_got_q[$];
  logic [7:0]             exp_dc_now = 8'd128;
  int                     cyc = 0;
  int                     pass_cnt = 0;
  int                     check_cnt = 0;

  function automatic res_t mk(input int dc, input int pp, input int rt, input int wt);
    res_t r;
    r.dc = 8'(dc); r.pp = 8'(pp); r.rt = 8'(rt); r.wt = 2'(wt); r.cyc = 0;
    return r;
  endfunction

  // Reference statistics straight from the definitions
  function automatic res_t model(input win_t s);
    longint sm = 0, sq = 0, mx = 0, mn = 255, vr, num, rq;
    int wt;
    for (int i = 0; i < WIN; i++) begin
      sm += s[i];
      sq += longint'(s[i]) * s[i];
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    vr  = (WIN * sq - sm * sm) / (WIN * WIN);
    num = 4 * (mx - mn) * (mx - mn);
    if (vr == 0) rq = 0;
    else begin
      rq = num / vr;
      if (rq > 255) rq = 255;
    end
    if (vr == 0)      wt = 0;
    else if (rq < 24) wt = 1;
    else if (rq >= 40) wt = 3;
    else              wt = 2;
    return mk(int'(sm / WIN), int'(mx - mn), int'(rq), wt);
  endfunction

  // One clock: observe outputs after the edge, record them, drive next inputs
  task automatic tick(input logic v, input logic [7:0] x);
    res_t r;
    logic signed [DATA_W:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (result_valid === 1'b1) begin
      r.dc = dc_offset; r.pp = vpp; r.rt = ratio; r.wt = wave_type; r.cyc = cyc;
      got_q.push_back(r);
      if (exp_q.size() >= got_q.size()) exp_dc_now = exp_q[got_q.size()-1].dc;
    end
    if (ac_valid === 1'b1) ac_got_q.push_back(ac_data);
    sample_valid = v;
    sample_data  = x;
    if (v) begin
      e = $signed({1'b0, x}) - $signed({1'b0, exp_dc_now});
      ac_exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 8'd0);
    tick(1'b0, 8'd0);
    rst = 1'b0;
    ac_exp_q.delete();
    ac_got_q.delete();
    exp_dc_now = 8'd128;
  endtask

  // Drive one window; the expected result is due 11 cycles after the last sample
  task automatic send_window(input win_t s, input res_t e, input bit gaps);
    int n;
    for (int i = 0; i < WIN; i++) begin
      tick(1'b1, 8'(s[i]));
      if (i == WIN - 1) begin
        e.cyc = cyc + 11;
        exp_q.push_back(e);
      end
      if (gaps) begin
        n = $urandom_range(3, 0);
        idle(n);
      end
    end
  endtask

  task automatic test_result_scoreboard(input string name);
    res_t e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check_cnt++;
        $display("FAIL %s missing result: got none, required dc=%0d due cycle %0d", name, e.dc, e.cyc);
      end else begin
        g = got_q.pop_front();
        check_cnt++;
        if (g.dc !== e.dc) $display("FAIL %s dc_offset: got %0d, required %0d", name, g.dc, e.dc);
        else pass_cnt++;
        check_cnt++;
        if (g.pp !== e.pp) $display("FAIL %s vpp: got %0d, required %0d", name, g.pp, e.pp);
        else pass_cnt++;
        check_cnt++;
        if (g.rt !== e.rt) $display("FAIL %s ratio: got %0d, required %0d", name, g.rt, e.rt);
        else pass_cnt++;
        check_cnt++;
        if (g.wt !== e.wt) $display("FAIL %s wave_type: got %0d, required %0d", name, g.wt, e.wt);
        else pass_cnt++;
        check_cnt++;
        if (g.cyc != e.cyc) $display("FAIL %s result cycle: got %0d, required %0d", name, g.cyc, e.cyc);
        else pass_cnt++;
      end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      check_cnt++;
      $display("FAIL %s unexpected result at cycle %0d: got dc=%0d, required none", name, g.cyc, g.dc);
    end
  endtask

  task automatic test_ac_path(input string name);
    logic signed [DATA_W:0] e, g;
    while (ac_exp_q.size() > 0) begin
      e = ac_exp_q.pop_front();
      check_cnt++;
      if (ac_got_q.size() == 0) begin
        $display("FAIL %s ac_data missing: got none, required %0d", name, e);
      end else begin
        g = ac_got_q.pop_front();
        if (g !== e) $display("FAIL %s ac_data: got %0d, required %0d", name, g, e);
        else pass_cnt++;
      end
    end
    while (ac_got_q.size() > 0) begin
      g = ac_got_q.pop_front();
      check_cnt++;
      $display("FAIL %s unexpected ac sample: got %0d, required none", name, g);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++;
    if (dc_offset !== 8'd128) $display("FAIL reset dc_offset: got %0d, required 128", dc_offset);
    else pass_cnt++;
    check_cnt++;
    if (vpp !== 8'd0) $display("FAIL reset vpp: got %0d, required 0", vpp);
    else pass_cnt++;
    check_cnt++;
    if (ratio !== 8'd0) $display("FAIL reset ratio: got %0d, required 0", ratio);
    else pass_cnt++;
    check_cnt++;
    if (wave_type !== 2'd0) $display("FAIL reset wave_type: got %0d, required 0", wave_type);
    else pass_cnt++;
    check_cnt++;
    if (result_valid !== 1'b0) $display("FAIL reset result_valid: got %0b, required 0", result_valid);
    else pass_cnt++;
    check_cnt++;
    if (ac_valid !== 1'b0) $display("FAIL reset ac_valid: got %0b, required 0", ac_valid);
    else pass_cnt++;
  endtask

  task automatic test_dc_constant();
    for (int i = 0; i < WIN; i++) begin
      tick(1'b1, 8'd77);
      if (i == 1) begin
        check_cnt++;
        if (ac_valid !== 1'b1 || ac_data !== -9'sd51)
          $display("FAIL dc_constant first ac: got valid=%0b data=%0d, required valid=1 data=-51", ac_valid, ac_data);
        else pass_cnt++;
      end
      if (i == WIN - 1) begin
        exp_q.push_back(mk(77, 0, 0, 0));
        exp_q[exp_q.size()-1].cyc = cyc + 11;
      end
    end
    idle(14);
    test_result_scoreboard("dc_constant");
    test_ac_path("dc_constant");
  endtask

  task automatic test_square();
    win_t s;
    for (int i = 0; i < WIN; i++) s[i] = (i < 16) ? 100 : 200;
    send_window(s, mk(150, 100, 16, 1), 1'b0);
    send_window(s, mk(150, 100, 16, 1), 1'b0);
    idle(14);
    // Second window after the first result: low half -50, high half +50
    check_cnt++;
    if (ac_got_q.size() < 17 || ac_got_q[ac_got_q.size()-17] !== -9'sd50)
      $display("FAIL square ac low half: got %0d, required -50",
               (ac_got_q.size() < 17) ? 0 : int'(ac_got_q[ac_got_q.size()-17]));
    else pass_cnt++;
    check_cnt++;
    if (ac_got_q.size() < 1 || ac_got_q[ac_got_q.size()-1] !== 9'sd50)
      $display("FAIL square ac high half: got %0d, required 50",
               (ac_got_q.size() < 1) ? 0 : int'(ac_got_q[ac_got_q.size()-1]));
    else pass_cnt++;
    test_result_scoreboard("square");
    test_ac_path("square");
  endtask

  task automatic test_sawtooth();
    win_t s;
    for (int i = 0; i < WIN; i++) s[i] = 8 * i;
    send_window(s, mk(124, 248, 45, 3), 1'b0);
    idle(14);
    test_result_scoreboard("sawtooth");
    test_ac_path("sawtooth");
  endtask

  task automatic test_sine();
    win_t s;
    for (int i = 0; i < WIN; i++)
      s[i] = $rtoi($floor(128.0 + 100.0 * $sin(2.0 * PI * i / 32.0) + 0.5));
    send_window(s, model(s), 1'b0);
    idle(14);
    check_cnt++;
    if (got_q.size() == 0) $display("FAIL sine range: got no result, required one");
    else if (got_q[0].rt < 31 || got_q[0].rt > 33 || got_q[0].wt !== 2'd2 ||
             got_q[0].pp < 199 || got_q[0].pp > 200)
      $display("FAIL sine range: got ratio=%0d vpp=%0d type=%0d, required ratio 31..33 vpp 199..200 type 2",
               got_q[0].rt, got_q[0].pp, got_q[0].wt);
    else pass_cnt++;
    test_result_scoreboard("sine");
    test_ac_path("sine");
  endtask

  task automatic test_back_to_back_gaps();
    win_t s;
    for (int i = 0; i < WIN; i++) s[i] = (i < 16) ? 100 : 200;
    for (int w = 0; w < 3; w++) send_window(s, mk(150, 100, 16, 1), 1'b1);
    idle(14);
    test_result_scoreboard("gapped");
    test_ac_path("gapped");
  endtask

  task automatic test_reset_mid_window();
    win_t s;
    for (int i = 0; i < 10; i++) tick(1'b1, 8'd100);
    do_reset();
    check_cnt++;
    if (dc_offset !== 8'd128) $display("FAIL mid_reset dc_offset: got %0d, required 128", dc_offset);
    else pass_cnt++;
    for (int i = 0; i < WIN; i++) s[i] = (i < 16) ? 100 : 200;
    send_window(s, mk(150, 100, 16, 1), 1'b0);
    idle(14);
    test_result_scoreboard("mid_reset");
    test_ac_path("mid_reset");
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    test_reset();
    test_dc_constant();
    test_square();
    test_sawtooth();
    test_sine();
    test_back_to_back_gaps();
    test_reset_mid_window();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
